// File: rtl/dict_ctrl_if.sv
// Lane-side bundle for dict_ctrl: compress request/grant/response channel
// and the decompress request/response channel.
interface dict_ctrl_if #(
    parameter int KEY_WIDTH = 4,
    parameter int VAL_WIDTH = 8,
    parameter int NUM_CREQ  = 2
);
    localparam int IDW = $clog2(NUM_CREQ);

    logic [NUM_CREQ-1:0]           c_req;
    logic [NUM_CREQ*VAL_WIDTH-1:0] c_val;
    logic [NUM_CREQ-1:0]           c_gnt;
    logic                          c_rsp_valid;
    logic [IDW-1:0]                c_rsp_id;
    logic [KEY_WIDTH-1:0]          c_rsp_key;
    logic                          c_rsp_hit;
    logic                          d_req;
    logic [KEY_WIDTH-1:0]          d_key;
    logic                          d_rsp_valid;
    logic [VAL_WIDTH-1:0]          d_rsp_val;

    modport master (
        output c_req, c_val, d_req, d_key,
        input  c_gnt, c_rsp_valid, c_rsp_id, c_rsp_key, c_rsp_hit,
        input  d_rsp_valid, d_rsp_val
    );

    modport slave (
        input  c_req, c_val, d_req, d_key,
        output c_gnt, c_rsp_valid, c_rsp_id, c_rsp_key, c_rsp_hit,
        output d_rsp_valid, d_rsp_val
    );
endinterface

// File: rtl/dict_ctrl.sv
// Dictionary load sequencer plus round-robin compress / dedicated decompress lookup front end.
// Optional hit/miss counters are enabled by defining DICT_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | dictionary not valid, waiting for load_start
// LOAD  | accepting ENTRIES contiguous beats into the dictionary
// READY | dictionary valid, lookups served
module dict_ctrl #(
    parameter int KEY_WIDTH = 4,
    parameter int VAL_WIDTH = 8,
    parameter int NUM_CREQ  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [VAL_WIDTH-1:0] load_data,
    output logic                 load_ready,
    output logic                 dict_ready,
    output logic                 load_err,
    output logic                 dict_we,
    output logic [VAL_WIDTH-1:0] dict_wval,
    output logic [KEY_WIDTH-1:0] dict_key,
    output logic [VAL_WIDTH-1:0] dict_val,
    input  logic [VAL_WIDTH-1:0] dict_val_out,
    input  logic [KEY_WIDTH-1:0] dict_key_out,
    input  logic                 dict_hit,
    dict_ctrl_if.slave           lane
`ifdef DICT_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_misses
`endif
);
    localparam int ENTRIES = 2**KEY_WIDTH;
    localparam int IDW     = $clog2(NUM_CREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]           state;
    logic [KEY_WIDTH-1:0] count;
    logic [IDW-1:0]       ptr;
    logic                 enter_load;
    logic                 serve;
    logic                 gnt_any;
    logic [IDW-1:0]       gnt_id;
    logic [IDW:0]         pos;

    assign load_ready = (state == LOAD);
    assign dict_ready = (state == READY);
    assign dict_we    = load_ready & load_valid;
    assign dict_wval  = load_data;
    assign dict_key   = lane.d_key;
    assign enter_load = load_start & ((state == IDLE) | (state == READY));
    // A reload request pre-empts every lookup issued in the same cycle.
    assign serve      = dict_ready & ~load_start;

    always_comb begin
        gnt_any    = 1'b0;
        gnt_id     = '0;
        pos        = '0;
        lane.c_gnt = '0;
        dict_val   = '0;
        if (serve) begin
            for (int k = 0; k < NUM_CREQ; k++) begin
                pos = {1'b0, ptr} + (IDW+1)'(k);
                if (pos >= (IDW+1)'(NUM_CREQ))
                    pos = pos - (IDW+1)'(NUM_CREQ);
                if (!gnt_any && lane.c_req[pos[IDW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_id  = pos[IDW-1:0];
                end
            end
        end
        if (gnt_any) begin
            lane.c_gnt[gnt_id] = 1'b1;
            dict_val           = lane.c_val[gnt_id*VAL_WIDTH +: VAL_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            load_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load_start) begin
                    state    <= LOAD;
                    count    <= '0;
                    load_err <= 1'b0;
                end
                LOAD: if (load_valid) begin
                    count <= count + KEY_WIDTH'(1);
                    if (count == KEY_WIDTH'(ENTRIES-1))
                        state <= READY;
                end else if (count != '0) begin
                    // Dictionary write index restarts on a gap, so the load is lost.
                    state    <= IDLE;
                    count    <= '0;
                    load_err <= 1'b1;
                end
                READY: if (load_start) begin
                    state <= LOAD;
                    count <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr              <= '0;
            lane.c_rsp_valid <= 1'b0;
            lane.c_rsp_id    <= '0;
            lane.c_rsp_key   <= '0;
            lane.c_rsp_hit   <= 1'b0;
            lane.d_rsp_valid <= 1'b0;
            lane.d_rsp_val   <= '0;
        end else begin
            lane.c_rsp_valid <= gnt_any;
            if (gnt_any) begin
                ptr            <= (gnt_id == IDW'(NUM_CREQ-1)) ? '0 : gnt_id + IDW'(1);
                lane.c_rsp_id  <= gnt_id;
                lane.c_rsp_key <= dict_hit ? dict_key_out : '0;
                lane.c_rsp_hit <= dict_hit;
            end
            lane.d_rsp_valid <= serve & lane.d_req;
            if (serve && lane.d_req)
                lane.d_rsp_val <= dict_val_out;
        end
    end

`ifdef DICT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || enter_load) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (lane.c_rsp_valid) begin
            if (lane.c_rsp_hit) begin
                if (stat_hits != 16'hFFFF)
                    stat_hits <= stat_hits + 16'd1;
            end else if (stat_misses != 16'hFFFF) begin
                stat_misses <= stat_misses + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/dict_ctrl.md
Name: dict_ctrl

Overview:
- Sequences the shared code-compression dictionary: loads all 2**KEY_WIDTH entries through its write port after reset or on request.
- Then serves lookups:
  - compress direction (value -> key/hit): shared by NUM_CREQ requesters under round-robin arbitration;
  - decompress direction (key -> value): one dedicated channel.
- Sits between the dictionary and the compressor/decompressor lanes. Owns dictionary ready status and load errors.

Parameters:
- KEY_WIDTH, 4, dictionary index width; entry count ENTRIES = 2**KEY_WIDTH.
- VAL_WIDTH, 8, uncompressed field width.
- NUM_CREQ, 2, compress-side requesters (2..8). IDW = clog2(NUM_CREQ).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- load_start  in  1  pulse: begin a full (re)load.
- load_valid  in  1  load beat valid.
- load_data  in  VAL_WIDTH  entry value; entries arrive in index order 0..ENTRIES-1.
- load_ready  out  1  high in LOAD.
- dict_ready  out  1  dictionary fully loaded, lookups served.
- load_err  out  1  sticky: last load aborted by a gap.
- dict_we  out  1  to dictionary write_enable.
- dict_wval  out  VAL_WIDTH  to dictionary write_val.
- dict_key  out  KEY_WIDTH  to dictionary key_lookup_in.
- dict_val  out  VAL_WIDTH  to dictionary val_lookup_in.
- dict_val_out  in  VAL_WIDTH  from dictionary val_out.
- dict_key_out  in  KEY_WIDTH  from dictionary key_out.
- dict_hit  in  1  from dictionary val_lookup_result.
- c_req  in  NUM_CREQ  compress requests, one bit per requester.
- c_val  in  NUM_CREQ*VAL_WIDTH  request values, requester i at slice [i*VAL_WIDTH +: VAL_WIDTH].
- c_gnt  out  NUM_CREQ  one-hot grant, combinational.
- c_rsp_valid  out  1  compress response valid.
- c_rsp_id  out  IDW  requester served.
- c_rsp_key  out  KEY_WIDTH  key found (0 on miss).
- c_rsp_hit  out  1  value present in dictionary.
- d_req  in  1  decompress request.
- d_key  in  KEY_WIDTH  key to expand.
- d_rsp_valid  out  1  decompress response valid.
- d_rsp_val  out  VAL_WIDTH  expanded value.

Behaviour:
- States: IDLE, LOAD, READY. Reset -> IDLE.
- Reset values: all registered outputs 0, load count 0, RR pointer 0, load_err 0. Combinational outputs at reset:
  - dict_we = 0, which also resets the dictionary's internal write index;
  - c_gnt = 0, load_ready = 0, dict_ready = 0.
- IDLE:
  - load_start -> LOAD; clear load_err and count.
  - No lookups served.
- LOAD:
  - load_ready = 1. dict_we = load_valid (combinational); dict_wval = load_data.
  - count increments per accepted beat.
  - Before the first beat, load_valid low is a legal wait.
  - After at least one beat, any cycle with load_valid = 0 is a gap. The dictionary index restarts on a gap, so: -> IDLE, load_err = 1 next cycle.
  - Beat accepted with count == ENTRIES-1 -> READY. count wraps to 0; no extra write occurs.
  - load_start while in LOAD is ignored.
- READY:
  - dict_ready = 1.
  - load_start has priority over all requests: -> LOAD, no grant that cycle, dict_ready drops next cycle.
- Compress arbitration (READY only):
  - c_gnt = first set c_req bit at or after the pointer, wrapping. dict_val = selected c_val (0 if none).
  - On grant i, the next cycle gives: c_rsp_valid = 1, c_rsp_id = i, c_rsp_key = dict_key_out, c_rsp_hit = dict_hit (dictionary outputs registered). Latency 1.
  - Pointer <- (i+1) mod NUM_CREQ on a grant; unchanged otherwise.
  - Requesters hold c_req/c_val until granted.
- Decompress: dict_key = d_key. In READY, d_req gives d_rsp_valid = 1, d_rsp_val = dict_val_out the next cycle. d_req outside READY is dropped, no response.
- Throughput: one compress and one decompress per cycle, concurrently. Response valids are single-cycle pulses; no backpressure on responses.
- Reset mid-operation: no responses emitted, dict_ready = 0, a reload is required.

Optional Feature:
- Macro DICT_CTRL_STATS_EN.
- Defined, adds outputs:
  - stat_hits [15:0] and stat_misses [15:0]: count registered compress responses by c_rsp_hit. Saturate at 16'hFFFF.
  - Both clear on reset and on entering LOAD.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, load_start, 16 contiguous beats 8'h10..8'h1F -> dict_we high exactly 16 cycles; dict_ready = 1 the cycle after beat 15; load_err = 0.
- Load 5 beats then load_valid low one cycle -> IDLE, load_err = 1, dict_ready = 0; next load_start clears load_err.
- READY, c_req = 2'b11 held with c_val0 = 8'h13, c_val1 = 8'hAA, 4 cycles -> grants alternate 01,10,01,10; responses id0 key 3 hit 1; id1 key 0 hit 0.
- READY, d_req with d_key = 4'hF concurrent with a compress grant -> both responses next cycle, d_rsp_val = 8'h1F.
- load_start in READY with c_req = 2'b01 -> c_gnt = 0 that cycle, no c_rsp_valid, load_ready next cycle.
- STATS_EN: 3 hits and 2 misses -> stat_hits = 3, stat_misses = 2; reload clears both to 0.
